// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared widths, register-zero constant and requester indices for the
// register-file writeback arbiter.
package regfile_wb_arbiter_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

    localparam logic REQ_ALU = 1'b0;
    localparam logic REQ_LD  = 1'b1;

    // r0 is hardwired, so it can never be the subject of a RAW hazard
    function automatic logic addr_hit(input logic [ADDR_W-1:0] src,
                                      input logic              pend_v,
                                      input logic [ADDR_W-1:0] pend_addr);
        return pend_v && (src != REG_ZERO) && (src == pend_addr);
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// One writeback requester's valid/ready channel carrying a destination
// register and its data.
interface regfile_wb_arbiter_if;
    import regfile_wb_arbiter_pkg::*;

    logic              valid;
    logic              ready;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;

    modport master (output valid, output addr, output data, input ready);
    modport slave  (input valid, input addr, input data, output ready);

endinterface

// File: rtl/regfile_wb_arbiter_hold_slot.sv
// One-entry holding buffer for a writeback requester, plus the mux that
// presents either the held entry or the live input as this cycle's candidate.
module wb_hold_slot
    import regfile_wb_arbiter_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    regfile_wb_arbiter_if.slave      req,
    input  logic                     grant,
    output logic                     cand_v,
    output logic [ADDR_W-1:0]        cand_addr,
    output logic [DATA_W-1:0]        cand_data,
    output logic                     hold_v,
    output logic [ADDR_W-1:0]        hold_addr
);

    logic [DATA_W-1:0] hold_data;
    logic              accept;

    assign req.ready = ~hold_v;
    assign accept    = req.valid & ~hold_v;
    assign cand_v    = hold_v | accept;
    assign cand_addr = hold_v ? hold_addr : req.addr;
    assign cand_data = hold_v ? hold_data : req.data;

    // An accepted input that loses arbitration parks here until granted
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_v    <= 1'b0;
            hold_addr <= '0;
            hold_data <= '0;
        end else if (hold_v) begin
            if (grant) begin
                hold_v <= 1'b0;
            end
        end else if (accept && !grant) begin
            hold_v    <= 1'b1;
            hold_addr <= req.addr;
            hold_data <= req.data;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the ALU
// and load writeback pipes, with RAW hazard detection for decode.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    regfile_wb_arbiter_if.slave in0,
    regfile_wb_arbiter_if.slave in1,
    output logic                wr_en,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [DATA_W-1:0]   wr_data,
    input  logic [ADDR_W-1:0]   rs,
    input  logic [ADDR_W-1:0]   rt,
    output logic                stall
);

    logic              cand0_v, cand1_v;
    logic [ADDR_W-1:0] cand0_addr, cand1_addr;
    logic [DATA_W-1:0] cand0_data, cand1_data;
    logic              hold0_v, hold1_v;
    logic [ADDR_W-1:0] hold0_addr, hold1_addr;
    logic              grant0, grant1;
    logic              last_grant;

    wb_hold_slot u_slot0 (
        .clk       (clk),
        .rst       (rst),
        .req       (in0),
        .grant     (grant0),
        .cand_v    (cand0_v),
        .cand_addr (cand0_addr),
        .cand_data (cand0_data),
        .hold_v    (hold0_v),
        .hold_addr (hold0_addr)
    );

    wb_hold_slot u_slot1 (
        .clk       (clk),
        .rst       (rst),
        .req       (in1),
        .grant     (grant1),
        .cand_v    (cand1_v),
        .cand_addr (cand1_addr),
        .cand_data (cand1_data),
        .hold_v    (hold1_v),
        .hold_addr (hold1_addr)
    );

    // On conflict the requester that did not win last time goes first
    assign grant0 = cand0_v & (~cand1_v | (last_grant == REQ_LD));
    assign grant1 = cand1_v & (~cand0_v | (last_grant == REQ_ALU));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            last_grant <= REQ_LD;
        end else if (grant0) begin
            wr_en      <= (cand0_addr != REG_ZERO);
            wr_addr    <= cand0_addr;
            wr_data    <= cand0_data;
            last_grant <= REQ_ALU;
        end else if (grant1) begin
            wr_en      <= (cand1_addr != REG_ZERO);
            wr_addr    <= cand1_addr;
            wr_data    <= cand1_data;
            last_grant <= REQ_LD;
        end else begin
            wr_en      <= 1'b0;
        end
    end

    assign stall = addr_hit(rs, hold0_v, hold0_addr) | addr_hit(rs, hold1_v, hold1_addr) |
                   addr_hit(rs, wr_en, wr_addr)      | addr_hit(rt, hold0_v, hold0_addr) |
                   addr_hit(rt, hold1_v, hold1_addr) | addr_hit(rt, wr_en, wr_addr);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: queue-based reference model checked
// every cycle, plus hand-computed expectations for the key scenarios.
module tb_regfile_wb_arbiter;
    import regfile_wb_arbiter_pkg::*;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } item_t;

    logic              clk;
    logic              rst;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] rs;
    logic [ADDR_W-1:0] rt;
    logic              stall;

    regfile_wb_arbiter_if in0_if ();
    regfile_wb_arbiter_if in1_if ();

    regfile_wb_arbiter dut (
        .clk     (clk),
        .rst     (rst),
        .in0     (in0_if),
        .in1     (in1_if),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rs      (rs),
        .rt      (rt),
        .stall   (stall)
    );

    int assertCount = 0;
    int failCount   = 0;

    item_t             q0[$];
    item_t             q1[$];
    bit                mLast;
    bit                expEn;
    logic [ADDR_W-1:0] expAddr;
    logic [DATA_W-1:0] expData;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [DATA_W-1:0] actual,
                               input logic [DATA_W-1:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit v0, input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0,
                                 input bit v1, input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1);
        in0_if.valid = v0;
        in0_if.addr  = a0;
        in0_if.data  = d0;
        in1_if.valid = v1;
        in1_if.addr  = a1;
        in1_if.data  = d1;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    function automatic bit pendingHit(input logic [ADDR_W-1:0] src);
        bit hit = 1'b0;
        if (src != 0) begin
            foreach (q0[i]) if (q0[i].a == src) hit = 1'b1;
            foreach (q1[i]) if (q1[i].a == src) hit = 1'b1;
            if (expEn && expAddr == src) hit = 1'b1;
        end
        return hit;
    endfunction

    // Reference model: each requester owns a one-deep queue; at most one item
    // is retired per edge, alternating when both queues have something.
    task automatic modelStep();
        item_t it;
        bit    have;
        if (!rst) begin
            q0.delete();
            q1.delete();
            mLast   = 1'b1;
            expEn   = 1'b0;
            expAddr = '0;
            expData = '0;
        end else begin
            if (in0_if.valid && in1_if.valid && in0_if.addr != 0 && in0_if.addr == in1_if.addr) begin
                assertCount++;
                failCount++;
                $display("[TB] FAIL illegal_same_addr: both requesters present r%0d", in0_if.addr);
            end
            if (in0_if.valid && q0.size() == 0) q0.push_back('{in0_if.addr, in0_if.data});
            if (in1_if.valid && q1.size() == 0) q1.push_back('{in1_if.addr, in1_if.data});
            have = 1'b1;
            if (q0.size() != 0 && (q1.size() == 0 || mLast == 1'b1)) begin
                it = q0.pop_front();
                mLast = 1'b0;
            end else if (q1.size() != 0) begin
                it = q1.pop_front();
                mLast = 1'b1;
            end else begin
                have = 1'b0;
            end
            if (have) begin
                expEn   = (it.a != 0);
                expAddr = it.a;
                expData = it.d;
            end else begin
                expEn = 1'b0;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst);
            modelStep();
        end
    end

    // Per-cycle comparison, placed away from edges and stimulus changes
    initial begin
        forever begin
            @(posedge clk);
            #4;
            checkOutput("model_wr_en",     wr_en,         expEn);
            checkOutput("model_wr_addr",   wr_addr,       expAddr);
            checkOutput("model_wr_data",   wr_data,       expData);
            checkOutput("model_in0_ready", in0_if.ready,  q0.size() == 0);
            checkOutput("model_in1_ready", in1_if.ready,  q1.size() == 0);
            checkOutput("model_stall",     stall,         pendingHit(rs) | pendingHit(rt));
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    int idx0, idx1;
    bit rdy0, rdy1;
    logic [ADDR_W-1:0] rrExp [6];

    initial begin
        rst = 1'b0;
        rs  = '0;
        rt  = '0;
        applyStimulus(0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        #1;
        checkOutput("reset_wr_en",   wr_en,        0);
        checkOutput("reset_wr_addr", wr_addr,      0);
        checkOutput("reset_wr_data", wr_data,      0);
        checkOutput("reset_ready0",  in0_if.ready, 1);
        checkOutput("reset_ready1",  in1_if.ready, 1);
        checkOutput("reset_stall_rt0", stall,      0);

        // Uncontended ALU write
        @(negedge clk);
        applyStimulus(1, 5, 32'hDEADBEEF, 0, 0, 0);
        @(posedge clk); #1;
        checkOutput("unc_wr_en",   wr_en,   1);
        checkOutput("unc_wr_addr", wr_addr, 5);
        checkOutput("unc_wr_data", wr_data, 32'hDEADBEEF);
        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        checkOutput("unc_pulse_end", wr_en,   0);
        checkOutput("unc_addr_held", wr_addr, 5);

        // Conflict straight after reset: ALU first, load one cycle later
        doReset();
        @(negedge clk);
        applyStimulus(1, 3, 32'h11, 1, 4, 32'h22);
        @(posedge clk); #1;
        checkOutput("conf_first_en",   wr_en,        1);
        checkOutput("conf_first_addr", wr_addr,      3);
        checkOutput("conf_first_data", wr_data,      32'h11);
        checkOutput("conf_ready1_low", in1_if.ready, 0);
        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        checkOutput("conf_second_en",   wr_en,        1);
        checkOutput("conf_second_addr", wr_addr,      4);
        checkOutput("conf_second_data", wr_data,      32'h22);
        checkOutput("conf_ready1_back", in1_if.ready, 1);
        @(posedge clk); #1;
        checkOutput("conf_idle", wr_en, 0);

        // Round-robin with both requesters always valid
        doReset();
        rrExp = '{5'd8, 5'd16, 5'd9, 5'd17, 5'd10, 5'd18};
        idx0 = 0;
        idx1 = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            applyStimulus(1, ADDR_W'(8 + idx0), DATA_W'(32'h100 + idx0),
                          1, ADDR_W'(16 + idx1), DATA_W'(32'h200 + idx1));
            rdy0 = in0_if.ready;
            rdy1 = in1_if.ready;
            @(posedge clk);
            if (rdy0) idx0++;
            if (rdy1) idx1++;
            #1;
            checkOutput($sformatf("rr_en_%0d", c),   wr_en,   1);
            checkOutput($sformatf("rr_addr_%0d", c), wr_addr, rrExp[c]);
        end
        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        checkOutput("rr_drain_addr", wr_addr, 11);
        checkOutput("rr_drain_data", wr_data, 32'h103);
        @(posedge clk); #1;
        checkOutput("rr_drain_idle", wr_en, 0);

        // Write to r0 consumes a slot but never asserts wr_en
        @(negedge clk);
        applyStimulus(0, 0, 0, 1, 0, 32'hFFFFFFFF);
        @(posedge clk); #1;
        checkOutput("r0_wr_en",   wr_en,        0);
        checkOutput("r0_wr_data", wr_data,      32'hFFFFFFFF);
        checkOutput("r0_ready1",  in1_if.ready, 1);
        @(negedge clk);
        applyStimulus(1, 12, 32'h1234, 0, 0, 0);
        @(posedge clk); #1;
        checkOutput("r0_next_en",   wr_en,   1);
        checkOutput("r0_next_addr", wr_addr, 12);
        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 0, 0);

        // Hazard against a held load to r7
        doReset();
        @(negedge clk);
        applyStimulus(1, 9, 32'hA, 1, 7, 32'hB);
        @(posedge clk); #1;
        rs = 7;
        #1;
        checkOutput("haz_hold_stall", stall,   1);
        checkOutput("haz_alu_addr",   wr_addr, 9);
        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        checkOutput("haz_r7_write", wr_addr, 7);
        checkOutput("haz_wr_stall", stall,   1);
        @(posedge clk); #1;
        checkOutput("haz_stall_drop", stall, 0);
        rs = 0;

        // Asynchronous reset in the middle of a write with a load held
        doReset();
        @(negedge clk);
        applyStimulus(1, 3, 32'h11, 1, 4, 32'h22);
        @(posedge clk); #1;
        checkOutput("mid_pre_en",     wr_en,        1);
        checkOutput("mid_pre_ready1", in1_if.ready, 0);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("mid_rst_en",     wr_en,        0);
        checkOutput("mid_rst_ready0", in0_if.ready, 1);
        checkOutput("mid_rst_ready1", in1_if.ready, 1);
        checkOutput("mid_rst_addr",   wr_addr,      0);
        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        checkOutput("mid_after_en1", wr_en, 0);
        @(posedge clk); #1;
        checkOutput("mid_after_en2", wr_en, 0);

        @(posedge clk); #6;
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
